// File: rtl/ccff_chain_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : ccff_chain_loader_if
//  Purpose  : Bitstream word stream (valid/ready) between the SoC bitstream
//             source and the configuration chain loader.
//  Signals  : s_data  - bitstream word, WORD_W bits
//             s_valid - s_data holds a word
//             s_ready - loader takes s_data this cycle
//  Modports : master (bitstream source), slave (chain loader)
//  Revision : 1.0  initial release
// ============================================================================
interface ccff_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ccff_chain_loader
//  Purpose  : Serialises bitstream words MSB first onto the configuration
//             chain head, generates the per-bit shift enable, keeps the
//             fabric isolated while loading and pulses done on completion.
//  Ports    : prog_clk, prog_reset_n (async, active low)
//             start, chain_len        - load request / total chain bits
//             s_if (slave)            - bitstream word stream
//             ccff_head, ccff_shift_en- registered serial data + advance
//             ccff_tail               - last chain stage (sentinel check)
//             isol_n, busy, done, err - status
//  Options  : CCFF_SENTINEL_CHECK_EN - prepend 8'hA5 and verify it emerges
//             on ccff_tail during the final 8 shifts (sets sticky err).
//  Revision : 1.0  initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 20
) (
    input  wire              prog_clk,
    input  wire              prog_reset_n,
    input  wire              start,
    input  wire  [CNT_W-1:0] chain_len,
    ccff_chain_loader_if.slave s_if,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    input  wire              ccff_tail,
    output logic             isol_n,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef CCFF_SENTINEL_CHECK_EN
    // Sentinel adds 8 shifts, so the remaining counter needs one extra bit.
    localparam int          c_rem_w    = CNT_W + 1;
    localparam logic [7:0]  c_sentinel = 8'hA5;
`else
    localparam int          c_rem_w    = CNT_W;
`endif
    localparam int c_wcnt_w = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_sreg;
    logic [c_rem_w-1:0]  r_remaining;
    logic [c_wcnt_w-1:0] r_word_cnt;
    logic                r_head;
    logic                r_shift_en;
    logic                r_isol_n;
    logic                r_busy;
    logic                r_done;

`ifdef CCFF_SENTINEL_CHECK_EN
    logic       r_err;
    logic       r_chk_en;   // ccff_tail must equal r_chk_bit this cycle
    logic       r_chk_bit;
    logic [2:0] w_sent_idx;

    // remaining 8..1 maps to sentinel bit 7..0 (MSB emerges first)
    assign w_sent_idx = 3'(r_remaining[2:0] - 3'd1);
    assign err        = r_err;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign err           = 1'b0;
`endif

    assign s_if.s_ready  = (r_state == S_LOAD);
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign isol_n        = r_isol_n;
    assign busy          = r_busy;
    assign done          = r_done;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_remaining <= '0;
            r_word_cnt  <= '0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_isol_n    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef CCFF_SENTINEL_CHECK_EN
            r_err       <= 1'b0;
            r_chk_en    <= 1'b0;
            r_chk_bit   <= 1'b0;
`endif
        end else begin
            r_shift_en <= 1'b0;
            r_done     <= 1'b0;
`ifdef CCFF_SENTINEL_CHECK_EN
            // The chain moves one cycle after the SHIFT state issued the bit,
            // so the expected tail bit is carried one cycle in r_chk_bit.
            r_chk_en <= 1'b0;
            if (r_chk_en && (ccff_tail != r_chk_bit)) begin
                r_err <= 1'b1;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_isol_n    <= 1'b0;
                        r_remaining <= c_rem_w'(chain_len);
`ifdef CCFF_SENTINEL_CHECK_EN
                        r_err       <= 1'b0;
`endif
                        if (chain_len == '0) begin
                            r_state <= S_DONE;
                        end else begin
`ifdef CCFF_SENTINEL_CHECK_EN
                            // Sentinel is shifted as a short pseudo-word first.
                            r_remaining <= c_rem_w'(chain_len) + c_rem_w'(8);
                            r_sreg      <= {c_sentinel, {(WORD_W-8){1'b0}}};
                            r_word_cnt  <= c_wcnt_w'(8);
                            r_state     <= S_SHIFT;
`else
                            r_state     <= S_LOAD;
`endif
                        end
                    end
                end
                S_LOAD: begin
                    if (s_if.s_valid) begin
                        r_sreg     <= s_if.s_data;
                        r_word_cnt <= c_wcnt_w'(WORD_W);
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_head      <= r_sreg[WORD_W-1];
                    r_shift_en  <= 1'b1;
                    r_sreg      <= {r_sreg[WORD_W-2:0], 1'b0};
                    r_remaining <= r_remaining - c_rem_w'(1);
                    r_word_cnt  <= r_word_cnt - c_wcnt_w'(1);
`ifdef CCFF_SENTINEL_CHECK_EN
                    if (r_remaining <= c_rem_w'(8)) begin
                        r_chk_en  <= 1'b1;
                        r_chk_bit <= c_sentinel[w_sent_idx];
                    end
`endif
                    // Chain end wins over word end: leftover word bits are dropped.
                    if (r_remaining == c_rem_w'(1)) begin
                        r_state <= S_DONE;
                    end else if (r_word_cnt == c_wcnt_w'(1)) begin
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_isol_n <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccff_chain_loader
//  Purpose  : Directed self-checking bench for ccff_chain_loader with a
//             16-stage chain model driving ccff_tail.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ccff_chain_loader;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 20;

    logic             prog_clk     = 1'b0;
    logic             prog_reset_n = 1'b0;
    logic             start        = 1'b0;
    logic [CNT_W-1:0] chain_len    = '0;
    logic             ccff_head;
    logic             ccff_shift_en;
    logic             ccff_tail;
    logic             isol_n;
    logic             busy;
    logic             done;
    logic             err;

    ccff_chain_loader_if #(.WORD_W(WORD_W)) s_if ();

    ccff_chain_loader #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .chain_len     (chain_len),
        .s_if          (s_if.slave),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .isol_n        (isol_n),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model and observation counters
    int          cyc            = 0;
    int          n_shifts       = 0;
    int          n_ready        = 0;
    int          last_shift_cyc = 0;
    int          done_cyc       = 0;
    logic [63:0] bits           = '0;
    logic [63:0] chain          = '0;

    assign ccff_tail = chain[15];

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (ccff_shift_en) begin
            n_shifts       <= n_shifts + 1;
            bits           <= {bits[62:0], ccff_head};
            chain          <= {chain[62:0], ccff_head};
            last_shift_cyc <= cyc;
        end
        if (done)         done_cyc <= cyc;
        if (s_if.s_ready) n_ready  <= n_ready + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int len);
        @(negedge prog_clk);
        chain_len = CNT_W'(len);
        start     = 1'b1;
        @(negedge prog_clk);
        start     = 1'b0;
    endtask

    task automatic send_word(input string tag, input logic [WORD_W-1:0] w);
        int t;
        t = 0;
        s_if.s_data  = w;
        s_if.s_valid = 1'b1;
        while (!s_if.s_ready && t < 200) begin
            @(negedge prog_clk);
            t++;
        end
        chk(tag, s_if.s_ready, 1'b1);
        @(negedge prog_clk);
        s_if.s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 300) begin
            @(negedge prog_clk);
            t++;
        end
        chk(tag, done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    int n0;
    int ns;
    int r0;
    int t;

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;

        // Reset values
        prog_reset_n = 1'b0;
        repeat (3) @(negedge prog_clk);
        chk("rst_s_ready",  s_if.s_ready,  1'b0);
        chk("rst_head",     ccff_head,     1'b0);
        chk("rst_shift_en", ccff_shift_en, 1'b0);
        chk("rst_busy",     busy,          1'b0);
        chk("rst_done",     done,          1'b0);
        chk("rst_err",      err,           1'b0);
        chk("rst_isol_n",   isol_n,        1'b0);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);

        // T2: one full word
        n0 = n_shifts;
        pulse_start(32);
        chk("t2_busy",   busy,         1'b1);
        chk("t2_isol",   isol_n,       1'b0);
        chk("t2_ready",  s_if.s_ready, 1'b1);
        send_word("t2_accept", 32'hDEADBEEF);
        wait_done("t2_done");
        chk("t2_nshift", 64'(n_shifts - n0), 64'd32);
        chk("t2_bits",   bits[31:0],         64'hDEADBEEF);
        chk("t2_isol_rel", isol_n,           1'b1);
        chk("t2_err",    err,                1'b0);
        @(negedge prog_clk);
        chk("t2_done_lat",   64'(done_cyc - last_shift_cyc), 64'd1);
        chk("t2_done_pulse", done, 1'b0);
        chk("t2_busy_off",   busy, 1'b0);

        // T3: two words, valid gap, partial final word, start while busy
        n0 = n_shifts;
        pulse_start(40);
        send_word("t3_accept1", 32'hFFFF0000);
        t = 0;
        while (!s_if.s_ready && t < 100) begin
            @(negedge prog_clk);
            t++;
        end
        chk("t3_reload", s_if.s_ready, 1'b1);
        @(negedge prog_clk);
        ns = n_shifts;
        chk("t3_word1_shifts", 64'(ns - n0), 64'd32);
        pulse_start(4);
        repeat (2) @(negedge prog_clk);
        chk("t3_gap_noshift", 64'(n_shifts - ns), 64'd0);
        chk("t3_busy_kept",   busy, 1'b1);
        send_word("t3_accept2", 32'hAB000000);
        wait_done("t3_done");
        chk("t3_nshift", 64'(n_shifts - n0), 64'd40);
        chk("t3_bits",   bits[39:0],         64'hFFFF0000AB);
        @(negedge prog_clk);

        // T4: zero-length chain
        n0 = n_shifts;
        r0 = n_ready;
        pulse_start(0);
        chk("t4_done_early", done, 1'b0);
        @(negedge prog_clk);
        chk("t4_done",   done,               1'b1);
        chk("t4_isol",   isol_n,             1'b1);
        @(negedge prog_clk);
        chk("t4_nshift", 64'(n_shifts - n0), 64'd0);
        chk("t4_noready", 64'(n_ready - r0), 64'd0);

        // T1: reset in the middle of shifting
        pulse_start(32);
        send_word("t1_accept", 32'hFFFFFFFF);
        repeat (6) @(negedge prog_clk);
        chk("t1_shifting", ccff_shift_en, 1'b1);
        chk("t1_head_hi",  ccff_head,     1'b1);
        prog_reset_n = 1'b0;
        #1;
        chk("t1_rst_shift_en", ccff_shift_en, 1'b0);
        chk("t1_rst_head",     ccff_head,     1'b0);
        chk("t1_rst_busy",     busy,          1'b0);
        chk("t1_rst_isol",     isol_n,        1'b0);
        chk("t1_rst_ready",    s_if.s_ready,  1'b0);
        ns = n_shifts;
        repeat (3) @(negedge prog_clk);
        chk("t1_no_shift", 64'(n_shifts - ns), 64'd0);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);

`ifdef CCFF_SENTINEL_CHECK_EN
        // T5: sentinel against a 16-stage chain
        n0 = n_shifts;
        pulse_start(16);
        send_word("t5_accept_ok", 32'h12345678);
        wait_done("t5_done_ok");
        chk("t5_err_ok",    err,                1'b0);
        chk("t5_nshift_ok", 64'(n_shifts - n0), 64'd24);
        chk("t5_bits_ok",   bits[23:0],         64'hA51234);
        @(negedge prog_clk);
        n0 = n_shifts;
        pulse_start(15);
        send_word("t5_accept_bad", 32'h12345678);
        wait_done("t5_done_bad");
        chk("t5_err_bad",    err,                1'b1);
        chk("t5_nshift_bad", 64'(n_shifts - n0), 64'd23);
        @(negedge prog_clk);
`endif

        // T6: back-to-back load after done
        pulse_start(32);
        chk("t6_isol_drop", isol_n, 1'b0);
        chk("t6_err_clr",   err,    1'b0);
        chk("t6_busy",      busy,   1'b1);
        send_word("t6_accept", 32'h0F0F00FF);
        wait_done("t6_done");
        chk("t6_bits", bits[31:0], 64'h0F0F00FF);
        @(negedge prog_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
